// File: rtl/phy_tx_lane_arbiter_if.sv
// phy_tx_lane_arbiter_if: requester handshakes and TX lane outputs of the lane arbiter
interface phy_tx_lane_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       last0;
  logic       req1;
  logic [7:0] data1;
  logic       last1;
  logic       ack0;
  logic       ack1;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant;
  modport master (
    output req0, data0, last0, req1, data1, last1,
    input  ack0, ack1, data_out, valid_out, grant
  );
  modport slave (
    input  req0, data0, last0, req1, data1, last1,
    output ack0, ack1, data_out, valid_out, grant
  );
endinterface

// File: rtl/phy_tx_lane_arbiter.sv
// phy_tx_lane_arbiter: round-robin, burst-granular sharing of one PHY TX byte lane between two requesters
module phy_tx_lane_arbiter #(
  parameter logic [7:0] COM_CHAR  = 8'hBC,
  parameter int         COM_GAP   = 2,
  parameter int         BURST_MAX = 16
) (
  input logic cclk,
  input logic default_values_n,
  phy_tx_lane_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int GW = COM_GAP > 1 ? $clog2(COM_GAP) : 1;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;
  state_t        r_state, w_state_nxt;
  logic          r_rr, w_rr_nxt;
  logic [CW-1:0] r_beat, w_beat_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid;
  logic [1:0]    r_grant, w_grant_nxt;
  logic          w_ack0, w_ack1, w_ack, w_last, w_end, w_gap_done;
  assign w_ack0     = r_state == GRANT0 && bus.req0;
  assign w_ack1     = r_state == GRANT1 && bus.req1;
  assign w_ack      = w_ack0 || w_ack1;
  assign w_last     = r_state == GRANT0 ? bus.last0 : bus.last1;
  assign w_end      = w_ack && (w_last || r_beat == CW'(BURST_MAX - 1));
  assign w_gap_done = r_gap == GW'(COM_GAP - 1);
  always_ff @(posedge cclk or negedge default_values_n) begin
    if (!default_values_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_beat  <= '0;
      r_gap   <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_beat  <= w_beat_nxt;
      r_gap   <= w_gap_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_ack;
      r_grant <= w_grant_nxt;
    end
  end
  // Requests seen while in GAP are ignored; arbitration only happens from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:           w_state_nxt = bus.req0 && (!bus.req1 || !r_rr) ? GRANT0 : bus.req1 ? GRANT1 : IDLE;
      GRANT0, GRANT1: w_state_nxt = !w_end ? r_state : COM_GAP > 0 ? GAP : IDLE;
      default:        w_state_nxt = w_gap_done ? IDLE : GAP;
    endcase
  end
  always_comb begin
    w_data_nxt  = w_ack0 ? bus.data0 : w_ack1 ? bus.data1 : COM_CHAR;
    w_beat_nxt  = w_end ? '0 : r_beat + CW'(w_ack);
    w_rr_nxt    = w_end ? r_state == GRANT0 : r_rr;
    w_gap_nxt   = r_state == GAP && !w_gap_done ? r_gap + GW'(1) : '0;
    w_grant_nxt = {w_state_nxt == GRANT1, w_state_nxt == GRANT0};
  end
  assign bus.ack0      = w_ack0;
  assign bus.ack1      = w_ack1;
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.grant     = r_grant;
endmodule
